rcos_mac_sched: RTL and testbench

Sequencer for the time-multiplexed raised-cosine FIR that shares one pre-adder/multiplier/accumulator across all taps on the fast clock. On each accepted input strobe it shifts the sample delay line once, steps the folded tap pairs and coefficient address through the shared MAC, then strobes the result out. It sits between the `din_en` sample strobe and the folded FIR datapath, and owns all of that datapath's enables.

---
 rtl/rcos_pkg.sv | 25 ++
 rtl/rcos_tap_addr.sv | 30 +++
 rtl/rcos_mac_sched.sv | 134 +++++++++++++
 tb/tb_rcos_mac_sched.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/rcos_pkg.sv
// rcos_pkg: shared definitions for the raised-cosine FIR MAC scheduler.
//   - sched_state_t : scheduler FSM state encoding (IDLE, LOAD, MAC, DUMP)
//   - NTAP_DEF      : default number of FIR taps
//   - nstep_f()     : MAC steps per sample for a given tap count
//   - TAP_W/COEF_W  : tap and coefficient index widths at the default NTAP
package rcos_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_MAC  = 2'd2,
    ST_DUMP = 2'd3
  } sched_state_t;

  localparam int NTAP_DEF = 9;

  // Folded symmetric FIR: one step per tap pair plus one for the centre tap.
  function automatic int nstep_f(input int ntap);
    return (ntap + 1) / 2;
  endfunction

  localparam int TAP_W  = $clog2(NTAP_DEF);
  localparam int COEF_W = $clog2(nstep_f(NTAP_DEF));

endpackage

// File: rtl/rcos_tap_addr.sv
// rcos_tap_addr: combinational map from MAC step to folded-FIR operand indices.
// Registered by the parent scheduler; also usable by a datapath checker.
// Ports:
//   step      in  : MAC step, 0..NSTEP-1
//   tap_lo    out : delay-line index of first pre-adder operand (= step)
//   tap_hi    out : delay-line index of second operand (= NTAP-1-step)
//   centre    out : last step, where tap_lo and tap_hi coincide
//   coef_addr out : coefficient ROM address (= step)
module rcos_tap_addr
  import rcos_pkg::*;
#(
  parameter int NTAP = NTAP_DEF
) (
  input  logic [$clog2(nstep_f(NTAP))-1:0] step,
  output logic [$clog2(NTAP)-1:0]          tap_lo,
  output logic [$clog2(NTAP)-1:0]          tap_hi,
  output logic                             centre,
  output logic [$clog2(nstep_f(NTAP))-1:0] coef_addr
);

  localparam int TW    = $clog2(NTAP);
  localparam int CW    = $clog2(nstep_f(NTAP));
  localparam int NSTEP = nstep_f(NTAP);

  assign tap_lo    = TW'(step);
  assign tap_hi    = TW'(NTAP - 1) - TW'(step);
  assign centre    = (step == CW'(NSTEP - 1));
  assign coef_addr = step;

endmodule

// File: rtl/rcos_mac_sched.sv
// rcos_mac_sched: sequencer for the time-shared raised-cosine FIR MAC.
// Each accepted din_en shifts the delay line once (LOAD), walks the folded tap
// pairs through the shared pre-adder/multiplier/accumulator (MAC, NSTEP
// cycles), then strobes the finished sum out (DUMP).
// Ports:
//   clk       in  : fast datapath clock
//   n_rst     in  : synchronous active-low reset
//   din_en    in  : one-cycle new-sample strobe
//   shift_en  out : delay line shifts in din
//   tap_lo    out : first pre-adder operand index
//   tap_hi    out : second pre-adder operand index
//   centre    out : centre tap, tap_hi ignored
//   coef_addr out : coefficient ROM address
//   acc_clr   out : accumulator loads product instead of adding
//   acc_en    out : accumulator updates
//   dout_en   out : output register captures accumulator
//   busy      out : high in LOAD and MAC
//   ovr       out : sticky overrun flag
//   ovr_cnt   out : saturating dropped-strobe count (RCOS_SCHED_OVR_CNT_EN only)
// Build option: define RCOS_SCHED_OVR_CNT_EN to add the ovr_cnt port.
module rcos_mac_sched
  import rcos_pkg::*;
#(
  parameter int NTAP = NTAP_DEF
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             din_en,
  output logic                             shift_en,
  output logic [$clog2(NTAP)-1:0]          tap_lo,
  output logic [$clog2(NTAP)-1:0]          tap_hi,
  output logic                             centre,
  output logic [$clog2(nstep_f(NTAP))-1:0] coef_addr,
  output logic                             acc_clr,
  output logic                             acc_en,
  output logic                             dout_en,
  output logic                             busy,
  output logic                             ovr
`ifdef RCOS_SCHED_OVR_CNT_EN
  ,
  output logic [7:0]                       ovr_cnt
`endif
);

  localparam int NSTEP = nstep_f(NTAP);
  localparam int TW    = $clog2(NTAP);
  localparam int CW    = $clog2(NSTEP);

  sched_state_t  state_reg, state_next;
  logic [CW-1:0] step_reg, step_next;
  logic          drop;

  logic [TW-1:0] dec_lo, dec_hi;
  logic [CW-1:0] dec_coef;
  logic          dec_centre;
  logic          mac_next;

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    drop       = 1'b0;
    case (state_reg)
      ST_IDLE: if (din_en) state_next = ST_LOAD;
      ST_LOAD: begin
        state_next = ST_MAC;
        step_next  = '0;
        drop       = din_en;
      end
      ST_MAC: begin
        drop = din_en;
        if (step_reg == CW'(NSTEP - 1)) begin
          state_next = ST_DUMP;
          step_next  = '0;
        end else begin
          step_next = step_reg + CW'(1);
        end
      end
      ST_DUMP: state_next = din_en ? ST_LOAD : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state/step so they appear registered
  // in the same cycle the FSM occupies that state.
  rcos_tap_addr #(.NTAP(NTAP)) u_tap_addr (
    .step      (step_next),
    .tap_lo    (dec_lo),
    .tap_hi    (dec_hi),
    .centre    (dec_centre),
    .coef_addr (dec_coef)
  );

  assign mac_next = (state_next == ST_MAC);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg <= ST_IDLE;
      step_reg  <= '0;
      shift_en  <= 1'b0;
      tap_lo    <= '0;
      tap_hi    <= '0;
      centre    <= 1'b0;
      coef_addr <= '0;
      acc_clr   <= 1'b0;
      acc_en    <= 1'b0;
      dout_en   <= 1'b0;
      busy      <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      shift_en  <= (state_next == ST_LOAD);
      tap_lo    <= mac_next ? dec_lo : '0;
      tap_hi    <= mac_next ? dec_hi : '0;
      centre    <= mac_next && dec_centre;
      coef_addr <= mac_next ? dec_coef : '0;
      acc_clr   <= mac_next && (step_next == '0);
      acc_en    <= mac_next;
      dout_en   <= (state_next == ST_DUMP);
      busy      <= (state_next == ST_LOAD) || mac_next;
      ovr       <= ovr || drop;
    end
  end

`ifdef RCOS_SCHED_OVR_CNT_EN
  always_ff @(posedge clk) begin
    if (!n_rst)
      ovr_cnt <= '0;
    else if (drop && (ovr_cnt != 8'hFF))
      ovr_cnt <= ovr_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_rcos_mac_sched.sv
// tb_rcos_mac_sched: table-driven bench for rcos_mac_sched at NTAP=9.
// Row i of the table is cycle i: inputs are driven just after the rising edge,
// outputs are checked at the falling edge of the same cycle.
module tb_rcos_mac_sched;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       din_en = 1'b0;
  logic       shift_en, centre, acc_clr, acc_en, dout_en, busy, ovr;
  logic [3:0] tap_lo, tap_hi;
  logic [2:0] coef_addr;
`ifdef RCOS_SCHED_OVR_CNT_EN
  logic [7:0] ovr_cnt;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  rcos_mac_sched #(.NTAP(9)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .din_en    (din_en),
    .shift_en  (shift_en),
    .tap_lo    (tap_lo),
    .tap_hi    (tap_hi),
    .centre    (centre),
    .coef_addr (coef_addr),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en),
    .dout_en   (dout_en),
    .busy      (busy),
    .ovr       (ovr)
`ifdef RCOS_SCHED_OVR_CNT_EN
    ,
    .ovr_cnt   (ovr_cnt)
`endif
  );

  logic [17:0] outv;
  assign outv = {shift_en, tap_lo, tap_hi, centre, coef_addr,
                 acc_clr, acc_en, dout_en, busy, ovr};

  function automatic logic [17:0] mk(bit sh, int lo, int hi, bit c, int cf,
                                     bit clr, bit en, bit dout, bit bsy, bit ov);
    return {sh, 4'(lo), 4'(hi), c, 3'(cf), clr, en, dout, bsy, ov};
  endfunction

  // Hand-listed MAC step expectations for NTAP=9.
  int lo_t  [5] = '{0, 1, 2, 3, 4};
  int hi_t  [5] = '{8, 7, 6, 5, 4};
  bit ce_t  [5] = '{0, 0, 0, 0, 1};
  bit clr_t [5] = '{1, 0, 0, 0, 0};

  function automatic logic [17:0] e_mac(int s, bit ov);
    return mk(0, lo_t[s], hi_t[s], ce_t[s], lo_t[s], clr_t[s], 1, 0, 1, ov);
  endfunction

  typedef struct {
    logic        din;
    logic        rst;
    logic [17:0] exp;
  } vec_t;

  localparam int NROW = 45;
  vec_t tbl [NROW];

  task automatic step(input logic d, input logic r, input logic [17:0] e, input int id);
    @(posedge clk);
    #1;
    din_en = d;
    n_rst  = r;
    @(negedge clk);
    checks++;
    if (outv !== e)
      $display("FAIL row%0d outputs got=%h want=%h", id, outv, e);
    else
      passed++;
  endtask

  task automatic check_val(input string nm, input int got, input int want);
    checks++;
    if (got != want)
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    else
      passed++;
  endtask

  initial begin
    int douts;

    // Build the directed table: single strobe at 10, back-to-back at 17,
    // overrun pair at 30/34, reset with coincident din_en at row 0.
    for (int i = 0; i < NROW; i++)
      tbl[i] = '{1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, i >= 35)};
    tbl[0].rst  = 1'b0;
    tbl[0].din  = 1'b1;
    tbl[10].din = 1'b1;
    tbl[17].din = 1'b1;
    tbl[30].din = 1'b1;
    tbl[34].din = 1'b1;
    tbl[11].exp = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[18].exp = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[31].exp = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int s = 0; s < 5; s++) begin
      tbl[12 + s].exp = e_mac(s, 0);
      tbl[19 + s].exp = e_mac(s, 0);
      tbl[32 + s].exp = e_mac(s, (32 + s) >= 35);
    end
    tbl[17].exp = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[24].exp = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[37].exp = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);

    repeat (3) @(posedge clk);
    for (int i = 0; i < NROW; i++)
      step(tbl[i].din, tbl[i].rst, tbl[i].exp, i);

`ifdef RCOS_SCHED_OVR_CNT_EN
    check_val("ovr_cnt_after_overrun", int'(ovr_cnt), 1);
`endif

    // Reset mid-run: sequence starts, reset asserted during MAC step 1.
    step(1, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 100);
    step(0, 1, mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1), 101);
    step(0, 1, e_mac(0, 1), 102);
    step(0, 0, e_mac(1, 1), 103);
    for (int i = 0; i < 8; i++)
      step(0, 1, 18'h0, 104 + i);
    // Normal sequence after release.
    step(1, 1, 18'h0, 112);
    step(0, 1, mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), 113);
    for (int s = 0; s < 5; s++)
      step(0, 1, e_mac(s, 0), 114 + s);
    step(0, 1, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 119);
    step(0, 1, 18'h0, 120);

    // Periodic strobes every 10 cycles, 100 samples.
    douts = 0;
    for (int n = 0; n < 100; n++) begin
      for (int c = 0; c < 10; c++) begin
        @(posedge clk);
        #1;
        din_en = (c == 0);
        @(negedge clk);
        if (dout_en) douts++;
      end
    end
    din_en = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (dout_en) douts++;
    end
    check_val("periodic_dout_count", douts, 100);
    check_val("periodic_ovr", int'(ovr), 0);

`ifdef RCOS_SCHED_OVR_CNT_EN
    // Saturation: holding din_en high drops 6 of every 7 strobes.
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(negedge clk);
    check_val("ovr_cnt_reset", int'(ovr_cnt), 0);
    din_en = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    din_en = 1'b0;
    @(negedge clk);
    check_val("ovr_cnt_saturate", int'(ovr_cnt), 255);
    check_val("ovr_sat_flag", int'(ovr), 1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
